// File: rtl/cpu_run_monitor.sv
// Run monitor for a single-issue core: watches retirements, detects exit
// syscalls, self-loop halts and watchdog expiry, and reports run statistics.
module cpu_run_monitor #(
    parameter int MAX_CYCLES   = 1000,
    parameter int LOOP_LIMIT   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        retire,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        running,
    output logic        done,
    output logic        timeout,
    output logic [31:0] exit_code,
    output logic [31:0] halt_pc,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        TIMEOUT
    } state_t;

    state_t      state;
    logic [31:0] same_cnt;
    logic [31:0] last_pc;
    logic [31:0] drain_cnt;

    logic        active;
    logic        is_syscall;
    logic        exit_hit;
    logic        loop_hit;
    logic        wd_hit;
    logic [31:0] same_next;
    logic [31:0] cyc_next;
    logic        unused_instr_bits;

    // The first retire out of IDLE is handled exactly like a RUN retire.
    assign active     = (state == RUN) || (state == IDLE && retire);
    assign is_syscall = (instr[31:26] == 6'h00) && (instr[5:0] == 6'h0C);
    assign exit_hit   = active && retire && is_syscall &&
                        (v0 == 32'd10 || v0 == 32'd17);
    assign same_next  = (state == RUN && pc == last_pc) ? same_cnt + 32'd1
                                                        : 32'd0;
    assign loop_hit   = active && retire && (same_next == 32'(LOOP_LIMIT));
    assign cyc_next   = cycle_count + 32'd1;
    assign wd_hit     = active && (cyc_next == 32'(MAX_CYCLES));

    assign unused_instr_bits = ^instr[25:6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            same_cnt    <= '0;
            last_pc     <= '0;
            drain_cnt   <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            halt_pc     <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (active) begin
                        state       <= RUN;
                        running     <= 1'b1;
                        cycle_count <= cyc_next;
                        if (retire) begin
                            instr_count <= instr_count + 32'd1;
                            last_pc     <= pc;
                            same_cnt    <= same_next;
                        end
                        // A real halt beats a watchdog expiry in the same cycle.
                        if (exit_hit || loop_hit) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                            halt_pc   <= pc;
                            if (exit_hit)
                                exit_code <= (v0 == 32'd10) ? 32'd0 : a0;
                            else
                                exit_code <= 32'hFFFF_FFFE;
                        end else if (wd_hit) begin
                            state     <= TIMEOUT;
                            running   <= 1'b0;
                            timeout   <= 1'b1;
                            exit_code <= 32'hFFFF_FFFF;
                            halt_pc   <= retire ? pc : last_pc;
                        end
                    end
                end
                DRAIN: begin
                    cycle_count <= cyc_next;
                    if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: a program-level reference model
// predicts each halt; a monitor checks it when done/timeout rises.
module tb_cpu_run_monitor;

    localparam int MAX_C = 1000;
    localparam int LOOP  = 4;
    localparam int DRAIN = 2;

    typedef struct packed {
        logic        retire;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] v0;
        logic [31:0] a0;
    } stim_t;

    typedef struct {
        bit          is_done;
        logic [31:0] code;
        logic [31:0] hpc;
        logic [31:0] cyc;
        logic [31:0] ic;
        int          t;
        int          edge_at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        retire = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        running;
    logic        done;
    logic        timeout;
    logic [31:0] exit_code;
    logic [31:0] halt_pc;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    int   checks = 0;
    int   failures = 0;
    int   edge_n = 0;
    exp_t sb[$];
    stim_t prog[$];

    cpu_run_monitor #(
        .MAX_CYCLES  (MAX_C),
        .LOOP_LIMIT  (LOOP),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .retire     (retire),
        .pc         (pc),
        .instr      (instr),
        .v0         (v0),
        .a0         (a0),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .exit_code  (exit_code),
        .halt_pc    (halt_pc),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Program-level reference: walks the cycle list applying the halt rules.
    function automatic exp_t model(input stim_t p[$]);
        exp_t        e;
        bit          started;
        int unsigned cyc;
        int unsigned ic;
        int unsigned run_len;
        logic [31:0] lastpc;
        bit          sys;
        e = '{is_done: 0, code: 0, hpc: 0, cyc: 0, ic: 0, t: -1, edge_at: 0};
        started = 0; cyc = 0; ic = 0; run_len = 0; lastpc = '0;
        foreach (p[t]) begin
            if (!started && !p[t].retire) continue;
            started = 1;
            cyc++;
            if (p[t].retire) begin
                ic++;
                if (ic > 1 && p[t].pc == lastpc) run_len++;
                else run_len = 1;
                lastpc = p[t].pc;
                sys = (p[t].instr[31:26] == 6'h00) && (p[t].instr[5:0] == 6'h0C);
                if (sys && (p[t].v0 == 10 || p[t].v0 == 17)) begin
                    e.is_done = 1;
                    e.code = (p[t].v0 == 10) ? 32'd0 : p[t].a0;
                    e.hpc = p[t].pc; e.cyc = cyc + DRAIN; e.ic = ic; e.t = t;
                    return e;
                end
                if (run_len == LOOP + 1) begin
                    e.is_done = 1; e.code = 32'hFFFF_FFFE;
                    e.hpc = p[t].pc; e.cyc = cyc + DRAIN; e.ic = ic; e.t = t;
                    return e;
                end
            end
            if (cyc == MAX_C) begin
                e.is_done = 0; e.code = 32'hFFFF_FFFF;
                e.hpc = lastpc; e.cyc = cyc; e.ic = ic; e.t = t;
                return e;
            end
        end
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, {29'd0, running, done, timeout}, 32'd0);
        chk({tag, "_exit_code"}, exit_code, 32'd0);
        chk({tag, "_halt_pc"}, halt_pc, 32'd0);
        chk({tag, "_cycle_count"}, cycle_count, 32'd0);
        chk({tag, "_instr_count"}, instr_count, 32'd0);
    endtask

    task automatic run_prog(input stim_t p[$], input int rst_at);
        exp_t e;
        int   start;
        int   last;
        stim_t s;
        e = model(p);
        last = (e.t >= 0) ? e.t + DRAIN + 6 : p.size() - 1;
        @(negedge clk);
        start = edge_n;
        if (e.t >= 0 && rst_at < 0) begin
            e.edge_at = start + e.t + 1 + (e.is_done ? DRAIN : 0);
            sb.push_back(e);
        end
        for (int t = 0; t <= last; t++) begin
            if (t > 0) @(negedge clk);
            if (t == rst_at) break;
            s = (t < p.size()) ? p[t] : '0;
            retire = s.retire; pc = s.pc; instr = s.instr;
            v0 = s.v0; a0 = s.a0;
        end
        if (rst_at < 0) @(negedge clk);
        reset = 1'b1; retire = 1'b1; pc = 32'h40;
        instr = 32'h0000_000C; v0 = 32'd10;
        @(negedge clk);
        reset = 1'b0; retire = 1'b0;
        check_zero("reset");
    endtask

    function automatic stim_t mk(input logic r, input logic [31:0] p_,
                                 input bit sys, input logic [31:0] v,
                                 input logic [31:0] a);
        stim_t s;
        s.retire = r; s.pc = p_;
        s.instr = sys ? {6'h00, 20'h00000, 6'h0C} : 32'h2008_0001;
        s.v0 = v; s.a0 = a;
        return s;
    endfunction

    // Monitor: pops the scoreboard when a halt becomes visible.
    initial begin : monitor
        exp_t e;
        bit   prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].is_done && edge_n == sb[0].edge_at - 1) begin
                chk("drain_running", {31'd0, running}, 32'd1);
                chk("drain_done_low", {31'd0, done}, 32'd0);
            end
            if ((done || timeout) && !prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_halt", {30'd0, done, timeout}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("halt_edge", edge_n, e.edge_at);
                    chk("halt_kind", {30'd0, done, timeout},
                        e.is_done ? 32'd2 : 32'd1);
                    chk("halt_running", {31'd0, running}, 32'd0);
                    chk("exit_code", exit_code, e.code);
                    chk("halt_pc", halt_pc, e.hpc);
                    chk("cycle_count", cycle_count, e.cyc);
                    chk("instr_count", instr_count, e.ic);
                    repeat (4) @(negedge clk);
                    chk("frozen_kind", {30'd0, done, timeout},
                        e.is_done ? 32'd2 : 32'd1);
                    chk("frozen_cycles", cycle_count, e.cyc);
                    chk("frozen_instrs", instr_count, e.ic);
                    chk("frozen_exit", exit_code, e.code);
                end
            end
            prev = done || timeout;
        end
    end

    initial begin : driver
        int same_pct;
        int sys_per_k;
        logic [31:0] cur_pc;
        stim_t s;
        repeat (3) @(negedge clk);
        retire = 1'b1;
        @(negedge clk);
        reset = 1'b0; retire = 1'b0;
        check_zero("init");

        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(mk(1, 32'(i * 4), 0, 0, 0));
        prog.push_back(mk(1, 32'h14, 1, 32'd10, 32'd0));
        run_prog(prog, -1);

        prog.delete();
        prog.push_back(mk(0, 32'h0, 0, 0, 0));
        prog.push_back(mk(1, 32'h100, 0, 0, 0));
        prog.push_back(mk(0, 32'h104, 0, 0, 0));
        prog.push_back(mk(1, 32'h104, 1, 32'd17, 32'h2A));
        run_prog(prog, -1);

        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(mk(1, 32'h40, 0, 0, 0));
        run_prog(prog, -1);

        prog.delete();
        for (int i = 0; i < 1010; i++) prog.push_back(mk(1, 32'(i * 4), 0, 0, 0));
        run_prog(prog, -1);

        prog.delete();
        for (int i = 0; i < 999; i++) prog.push_back(mk(1, 32'(i * 4), 0, 0, 0));
        prog.push_back(mk(1, 32'h0000_0F9C, 1, 32'd10, 32'd7));
        run_prog(prog, -1);

        prog.delete();
        prog.push_back(mk(1, 32'h0, 0, 0, 0));
        prog.push_back(mk(1, 32'h4, 0, 0, 0));
        prog.push_back(mk(1, 32'h8, 1, 32'd10, 32'd0));
        for (int i = 0; i < 4; i++) prog.push_back(mk(1, 32'h80, 0, 0, 0));
        run_prog(prog, 4);

        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back(mk(1, 32'(i * 4), 0, 0, 0));
        prog.push_back(mk(1, 32'h0C, 1, 32'd17, 32'h55));
        run_prog(prog, -1);

        for (int n = 0; n < 14; n++) begin
            same_pct  = (n % 3 == 0) ? 0 : 35;
            sys_per_k = (n % 4 == 1) ? 0 : 4;
            prog.delete();
            cur_pc = 32'($urandom_range(0, 63)) << 2;
            for (int t = 0; t < 1010; t++) begin
                if ($urandom_range(0, 99) >= same_pct)
                    cur_pc = 32'($urandom_range(0, 63)) << 2;
                s.retire = (t == 0) || ($urandom_range(0, 99) < 75);
                s.pc = cur_pc;
                s.a0 = $urandom;
                if ($urandom_range(0, 999) < sys_per_k) begin
                    s.instr = {6'h00, 20'($urandom), 6'h0C};
                    case ($urandom_range(0, 3))
                        0: s.v0 = 32'd10;
                        1: s.v0 = 32'd17;
                        2: s.v0 = 32'd5;
                        default: s.v0 = $urandom;
                    endcase
                end else begin
                    s.instr = $urandom | 32'h0400_0000;
                    s.v0 = 32'($urandom_range(0, 20));
                end
                prog.push_back(s);
            end
            run_prog(prog, -1);
        end

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 1000, meaning the watchdog limit in clk cycles (1000 x 20 ns = 20 us).
REQ-002 SHALL have parameter LOOP_LIMIT, default 4, meaning the number of consecutive same-PC retirements that declares a self-loop halt.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 2, meaning the number of cycles between halt detection and done, so final memory/register writes commit.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port retire  input  1  one instruction retired this cycle.
REQ-007 SHALL have port pc  input  32  byte address of the retiring instruction.
REQ-008 SHALL have port instr  input  32  encoding of the retiring instruction.
REQ-009 SHALL have port v0  input  32  register $2 value at retirement.
REQ-010 SHALL have port a0  input  32  register $4 value at retirement.
REQ-011 SHALL have port running  output  1  high in RUN and DRAIN.
REQ-012 SHALL have port done  output  1  program halted normally (sticky).
REQ-013 SHALL have port timeout  output  1  watchdog expired (sticky).
REQ-014 SHALL have port exit_code  output  32  halt reason/value.
REQ-015 SHALL have port halt_pc  output  32  pc of the halting instruction.
REQ-016 SHALL have port cycle_count  output  32  cycles spent in RUN+DRAIN.
REQ-017 SHALL have port instr_count  output  32  instructions retired in RUN.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, TIMEOUT.
REQ-019 IDLE SHALL go to RUN on the first retire; that retire SHALL be processed as a RUN retire in the same cycle.
REQ-020 SHALL decode a syscall as instr[31:26]==6'h00 and instr[5:0]==6'h0C.
REQ-021 Retired syscall with v0==10 SHALL latch exit_code=0 and halt_pc=pc, then go to DRAIN.
REQ-022 Retired syscall with v0==17 SHALL latch exit_code=a0 and halt_pc=pc, then go to DRAIN.
REQ-023 A syscall with any other v0 SHALL be counted as a normal instruction.
REQ-024 SHALL count consecutive retires whose pc equals the previously retired pc.
REQ-025 Non-retire cycles SHALL neither reset nor advance the same-PC count.
REQ-026 A retire with a different pc SHALL reset the same-PC count to 0.
REQ-027 When the same-PC count reaches LOOP_LIMIT (4 same-pc retires after the first at that pc), SHALL latch exit_code=32'hFFFF_FFFE and halt_pc=pc, then go to DRAIN.
REQ-028 cycle_count SHALL increment by 1 every cycle in RUN and DRAIN, including the IDLE->RUN transition cycle.
REQ-029 cycle_count SHALL freeze in DONE and TIMEOUT.
REQ-030 instr_count SHALL increment on every retire processed in RUN, including the halting instruction.
REQ-031 Retires in DRAIN, DONE and TIMEOUT SHALL be ignored.
REQ-032 In RUN, when the incremented cycle_count equals MAX_CYCLES with no halt this cycle, SHALL latch exit_code=32'hFFFF_FFFF and halt_pc=last retired pc, then go to TIMEOUT.
REQ-033 A syscall exit or loop halt in the same cycle as watchdog expiry SHALL take priority: the block goes to DRAIN, not TIMEOUT.
REQ-034 The watchdog SHALL not fire in DRAIN.
REQ-035 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then go to DONE.
REQ-036 done SHALL assert on the first DONE cycle; timeout SHALL assert on the first TIMEOUT cycle.
REQ-037 DONE and TIMEOUT SHALL be absorbing until reset.
REQ-038 All outputs SHALL be registered; counters SHALL wrap modulo 2^32.

Reset
REQ-039 reset SHALL take priority over all other inputs in any state, including mid-DRAIN.
REQ-040 reset SHALL force state IDLE and the same-PC count to 0.
REQ-041 reset SHALL force running=0, done=0, timeout=0, exit_code=0, halt_pc=0, cycle_count=0, instr_count=0.
REQ-042 A retire asserted during reset SHALL be ignored.

Verification
REQ-043 Retire 5 non-syscall instrs at pc 0x0..0x10, then syscall at 0x14 with v0=10 -> done high 2 cycles after the syscall; exit_code=0, halt_pc=0x14, instr_count=6.
REQ-044 Syscall with v0=17, a0=0x2A -> exit_code=0x2A, done=1, timeout=0.
REQ-045 Five consecutive retires at pc 0x40 -> exit_code=0xFFFFFFFE, halt_pc=0x40, done=1.
REQ-046 MAX_CYCLES=1000 with continuous retires of distinct pcs and no syscall -> timeout=1 and cycle_count=1000 in the cycle after expiry, done stays 0, counters frozen thereafter.
REQ-047 Exit syscall on the cycle the watchdog would expire -> done=1, timeout=0, exit_code=0.
REQ-048 Reset asserted during DRAIN -> the next cycle shows all outputs 0 and state IDLE; a following program halts normally.
